// File: rtl/wb_arbiter_if.sv
// Register-file write-port arbitration bus: the channel 0 pipeline
// write, the long-latency channel valid/ready handshakes and the
// registered register-file write port.
interface wb_arbiter_if #(
    parameter int XLEN   = 32,
    parameter int NUM_CH = 4
);
    // Channel 0 (in-order pipeline)
    logic                            p_valid_i;
    logic                            p_hold_i;
    logic                            p_flush_i;
    logic [4:0]                      p_rd_i;
    logic [1:0]                      p_data_sel_i;
    logic [XLEN-1:0]                 p_pc_incr_i;
    logic [XLEN-1:0]                 p_alu_i;
    logic [XLEN-1:0]                 p_rdata_i;
    logic [1:0]                      p_size_i;
    logic                            p_unsigned_i;
    logic                            p_hold_o;

    // Long-latency channels, indexed by channel number 1..NUM_CH-1
    logic [NUM_CH-1:1]               a_valid_i;
    logic [NUM_CH-1:1]               a_ready_o;
    logic [NUM_CH-1:1][4:0]          a_rd_i;
    logic [NUM_CH-1:1][XLEN-1:0]     a_data_i;

    // Register-file write port
    logic                            rf_we_o;
    logic [4:0]                      rf_waddr_o;
    logic [XLEN-1:0]                 rf_wdata_o;

    modport slave (
        input  p_valid_i, p_hold_i, p_flush_i, p_rd_i, p_data_sel_i,
        input  p_pc_incr_i, p_alu_i, p_rdata_i, p_size_i, p_unsigned_i,
        input  a_valid_i, a_rd_i, a_data_i,
        output p_hold_o, a_ready_o,
        output rf_we_o, rf_waddr_o, rf_wdata_o
    );

    modport master (
        output p_valid_i, p_hold_i, p_flush_i, p_rd_i, p_data_sel_i,
        output p_pc_incr_i, p_alu_i, p_rdata_i, p_size_i, p_unsigned_i,
        output a_valid_i, a_rd_i, a_data_i,
        input  p_hold_o, a_ready_o,
        input  rf_we_o, rf_waddr_o, rf_wdata_o
    );
endinterface

// File: rtl/wb_arbiter.sv
// Write-back arbiter: shares the single register-file write port between
// the in-order pipeline (channel 0) and the long-latency result channels.
// The pipeline normally has priority; long-latency channels are served
// round-robin in idle pipeline slots, and a channel that has waited
// STARVE_LIM cycles stalls the pipeline to force its way in.
module wb_arbiter #(
    parameter int XLEN       = 32,
    parameter int NUM_CH     = 4,
    parameter int STARVE_LIM = 8
) (
    input logic         clk_i,
    input logic         rst_ni,
    wb_arbiter_if.slave bus
);
    localparam int              NA      = NUM_CH - 1;
    localparam logic [7:0]      LIM     = 8'(STARVE_LIM);
    localparam logic [NA-1:0]   RR_INIT = NA'(1);

    logic                        p_wr_base;
    logic                        p_wr_eff;
    logic                        p_hold;
    logic [XLEN-1:0]             load_ext;
    logic [XLEN-1:0]             p_data;

    logic [NUM_CH-1:1]           starve;
    logic [NUM_CH-1:1]           grant_oh;
    logic                        found;
    logic [NUM_CH-1:1]           rr_q, rr_d;
    logic [NUM_CH-1:1][7:0]      age_q, age_d;

    logic [4:0]                  g_rd;
    logic [XLEN-1:0]             g_data;

    logic                        rf_we_q, rf_we_d;
    logic [4:0]                  rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0]             rf_wdata_q, rf_wdata_d;

    // Pipeline wants the port unless stalled or flushed; a starving channel
    // takes the port from it, which is reported back as a stall request.
    assign p_wr_base = bus.p_valid_i & ~bus.p_hold_i & ~bus.p_flush_i;
    assign p_hold    = rst_ni & (|starve) & bus.p_valid_i & ~bus.p_flush_i;
    assign p_wr_eff  = p_wr_base & ~p_hold;

    assign bus.p_hold_o   = p_hold;
    assign bus.a_ready_o  = rst_ni ? grant_oh : '0;
    assign bus.rf_we_o    = rf_we_q;
    assign bus.rf_waddr_o = rf_waddr_q;
    assign bus.rf_wdata_o = rf_wdata_q;

    // Channel 0 result: pc+4, size/sign-extended load data or ALU result
    always_comb begin
        load_ext = bus.p_rdata_i;
        case (bus.p_size_i)
            2'b00:   load_ext = {{(XLEN-8){bus.p_rdata_i[7] & ~bus.p_unsigned_i}},
                                 bus.p_rdata_i[7:0]};
            2'b01:   load_ext = {{(XLEN-16){bus.p_rdata_i[15] & ~bus.p_unsigned_i}},
                                 bus.p_rdata_i[15:0]};
            default: load_ext = bus.p_rdata_i;
        endcase
        if (bus.p_data_sel_i[1]) begin
            p_data = bus.p_pc_incr_i;
        end else if (bus.p_data_sel_i[0]) begin
            p_data = load_ext;
        end else begin
            p_data = bus.p_alu_i;
        end
    end

    // A channel is starving once its wait count has saturated while still requesting
    always_comb begin
        starve = '0;
        for (int k = 1; k < NUM_CH; k++) begin
            starve[k] = bus.a_valid_i[k] & (age_q[k] == LIM);
        end
    end

    // Grant selection: lowest starving channel first, else round-robin in idle pipeline slots
    always_comb begin
        grant_oh = '0;
        found    = 1'b0;
        if (|starve) begin
            for (int k = NUM_CH - 1; k >= 1; k--) begin
                if (starve[k]) begin
                    grant_oh    = '0;
                    grant_oh[k] = 1'b1;
                end
            end
        end else if (!p_wr_base) begin
            // i is the search distance from the pointer, so nearer channels win
            for (int i = 0; i < NA; i++) begin
                for (int s = 1; s <= NA; s++) begin
                    for (int c = 1; c <= NA; c++) begin
                        if ((((c - s + NA) % NA) == i) && rr_q[s] &&
                            bus.a_valid_i[c] && !found) begin
                            grant_oh[c] = 1'b1;
                            found       = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Wait-age bookkeeping and round-robin pointer advance past the winner
    always_comb begin
        age_d = age_q;
        rr_d  = rr_q;
        for (int k = 1; k < NUM_CH; k++) begin
            if (!bus.a_valid_i[k] || grant_oh[k]) begin
                age_d[k] = '0;
            end else if (age_q[k] != LIM) begin
                age_d[k] = age_q[k] + 8'd1;
            end
        end
        if (|grant_oh) begin
            rr_d = '0;
            for (int k = 1; k < NUM_CH; k++) begin
                if (grant_oh[k]) begin
                    rr_d[(k == NA) ? 1 : k + 1] = 1'b1;
                end
            end
        end
    end

    // Next write-port contents; x0 destinations complete without writing
    always_comb begin
        g_rd       = '0;
        g_data     = '0;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        for (int k = 1; k < NUM_CH; k++) begin
            if (grant_oh[k]) begin
                g_rd   = bus.a_rd_i[k];
                g_data = bus.a_data_i[k];
            end
        end
        if (|grant_oh) begin
            if (g_rd != 5'd0) begin
                rf_we_d    = 1'b1;
                rf_waddr_d = g_rd;
                rf_wdata_d = g_data;
            end
        end else if (p_wr_eff && (bus.p_rd_i != 5'd0)) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = bus.p_rd_i;
            rf_wdata_d = p_data;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            age_q      <= '0;
            rr_q       <= RR_INIT;
        end else begin
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            age_q      <= age_d;
            rr_q       <= rr_d;
        end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: a behavioural reference model
// predicts grants/stalls each cycle and pushes the expected write-port
// contents to a scoreboard that is popped after the clock edge.
module tb_wb_arbiter;
    localparam int XLEN   = 32;
    localparam int NUM_CH = 4;
    localparam int LIM    = 8;

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    wb_arbiter_if #(.XLEN(XLEN), .NUM_CH(NUM_CH)) bus ();

    wb_arbiter #(
        .XLEN       (XLEN),
        .NUM_CH     (NUM_CH),
        .STARVE_LIM (LIM)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    wr_t          sb_q[$];
    int           n_checks = 0;
    int           n_fail   = 0;

    int           m_age[1:3];
    int           m_rr;
    logic [4:0]   m_addr;
    logic [31:0]  m_data;

    logic [3:1]   last_ready;
    logic         last_hold;

    task automatic checkOutput(input string tag, input logic [63:0] obs,
                               input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic setPipe(input logic v, input logic h, input logic f,
                           input logic [4:0] rd, input logic [1:0] sel,
                           input logic [1:0] sz, input logic uns,
                           input logic [31:0] pc, input logic [31:0] alu,
                           input logic [31:0] rdata);
        bus.p_valid_i    = v;
        bus.p_hold_i     = h;
        bus.p_flush_i    = f;
        bus.p_rd_i       = rd;
        bus.p_data_sel_i = sel;
        bus.p_size_i     = sz;
        bus.p_unsigned_i = uns;
        bus.p_pc_incr_i  = pc;
        bus.p_alu_i      = alu;
        bus.p_rdata_i    = rdata;
    endtask

    task automatic setChan(input int k, input logic v, input logic [4:0] rd,
                           input logic [31:0] d);
        bus.a_valid_i[k] = v;
        bus.a_rd_i[k]    = rd;
        bus.a_data_i[k]  = d;
    endtask

    task automatic idleAll();
        setPipe(0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
        for (int k = 1; k < NUM_CH; k++) setChan(k, 0, 0, 0);
    endtask

    // Reference value of a channel 0 write
    function automatic logic [31:0] ch0Value();
        logic [31:0] r;
        r = bus.p_rdata_i;
        if (bus.p_data_sel_i[1]) return bus.p_pc_incr_i;
        if (!bus.p_data_sel_i[0]) return bus.p_alu_i;
        case (bus.p_size_i)
            2'b00:   return bus.p_unsigned_i ? 32'(r[7:0])  : 32'($signed(r[7:0]));
            2'b01:   return bus.p_unsigned_i ? 32'(r[15:0]) : 32'($signed(r[15:0]));
            default: return r;
        endcase
    endfunction

    // One clock: predict, check combinational outputs, push, clock, pop/compare
    task automatic applyStimulus(input string tag);
        logic [3:1] exp_ready;
        logic       exp_hold;
        logic       base;
        logic       r;
        int         g;
        int         c;
        int         n_age[1:3];
        int         n_rr;
        wr_t        e;
        wr_t        got;
        #1;
        r         = rst_n;
        exp_ready = '0;
        exp_hold  = 1'b0;
        g         = 0;
        base      = bus.p_valid_i && !bus.p_hold_i && !bus.p_flush_i;
        if (r) begin
            for (int k = 3; k >= 1; k--)
                if (bus.a_valid_i[k] && m_age[k] == LIM) g = k;
            if (g != 0) begin
                exp_hold = bus.p_valid_i && !bus.p_flush_i;
            end else if (!base) begin
                for (int i = 0; i < 3; i++) begin
                    c = ((m_rr - 1 + i) % 3) + 1;
                    if (g == 0 && bus.a_valid_i[c]) g = c;
                end
            end
            if (g != 0) exp_ready[g] = 1'b1;
        end
        e.we   = 1'b0;
        e.addr = m_addr;
        e.data = m_data;
        if (!r) begin
            e.addr = 0;
            e.data = 0;
        end else if (g != 0) begin
            if (bus.a_rd_i[g] != 0) begin
                e.we   = 1'b1;
                e.addr = bus.a_rd_i[g];
                e.data = bus.a_data_i[g];
            end
        end else if (base && !exp_hold && bus.p_rd_i != 0) begin
            e.we   = 1'b1;
            e.addr = bus.p_rd_i;
            e.data = ch0Value();
        end
        n_rr = m_rr;
        for (int k = 1; k <= 3; k++) begin
            if (!r || !bus.a_valid_i[k] || k == g) n_age[k] = 0;
            else n_age[k] = (m_age[k] < LIM) ? m_age[k] + 1 : LIM;
        end
        if (!r) n_rr = 1;
        else if (g != 0) n_rr = (g == 3) ? 1 : g + 1;

        last_ready = bus.a_ready_o;
        last_hold  = bus.p_hold_o;
        checkOutput({tag, "/ready"}, 64'(bus.a_ready_o), 64'(exp_ready));
        checkOutput({tag, "/hold"}, 64'(bus.p_hold_o), 64'(exp_hold));
        sb_q.push_back(e);

        @(posedge clk);
        m_age  = n_age;
        m_rr   = n_rr;
        m_addr = e.addr;
        m_data = e.data;
        #1;
        if (sb_q.size() == 0) begin
            checkOutput({tag, "/sb_underflow"}, 64'(1), 64'(0));
        end else begin
            got = sb_q.pop_front();
            checkOutput({tag, "/we"},    64'(bus.rf_we_o),    64'(got.we));
            checkOutput({tag, "/waddr"}, 64'(bus.rf_waddr_o), 64'(got.addr));
            checkOutput({tag, "/wdata"}, 64'(bus.rf_wdata_o), 64'(got.data));
        end
        @(negedge clk);
    endtask

    // Safety net in case the clock or a wait never completes
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Directed scenarios followed by a randomised phase
    initial begin
        int         waited;
        logic       got_grant;
        logic [3:1] grants[4];

        for (int k = 1; k <= 3; k++) m_age[k] = 0;
        m_rr   = 1;
        m_addr = 0;
        m_data = 0;
        idleAll();
        rst_n = 1'b0;
        @(negedge clk);
        applyStimulus("rst0");

        // Requests during reset must not be granted or stall the pipeline
        setPipe(1, 0, 0, 5'd9, 2'b00, 2'b10, 0, 0, 32'h1111, 0);
        setChan(1, 1, 5'd3, 32'h33);
        setChan(3, 1, 5'd4, 32'h44);
        applyStimulus("rst1");
        checkOutput("rst_we",    64'(bus.rf_we_o),    64'(0));
        checkOutput("rst_waddr", 64'(bus.rf_waddr_o), 64'(0));
        checkOutput("rst_wdata", 64'(bus.rf_wdata_o), 64'(0));
        checkOutput("rst_ready", 64'(last_ready),     64'(0));

        rst_n = 1'b1;
        idleAll();

        // Signed byte load
        setPipe(1, 0, 0, 5'd5, 2'b01, 2'b00, 0, 32'h1000, 32'h2222, 32'h0000_0080);
        applyStimulus("ld_byte");
        checkOutput("ld_byte_we",    64'(bus.rf_we_o),    64'(1));
        checkOutput("ld_byte_waddr", 64'(bus.rf_waddr_o), 64'(5));
        checkOutput("ld_byte_wdata", 64'(bus.rf_wdata_o), 64'(32'hFFFF_FF80));

        setPipe(1, 0, 0, 5'd6, 2'b01, 2'b01, 1, 0, 0, 32'h1234_8001);
        applyStimulus("ld_hu");
        checkOutput("ld_hu_wdata", 64'(bus.rf_wdata_o), 64'(32'h0000_8001));
        setPipe(1, 0, 0, 5'd7, 2'b01, 2'b01, 0, 0, 0, 32'h0000_8001);
        applyStimulus("ld_h");
        checkOutput("ld_h_wdata", 64'(bus.rf_wdata_o), 64'(32'hFFFF_8001));
        setPipe(1, 0, 0, 5'd8, 2'b01, 2'b10, 0, 0, 0, 32'h8765_4321);
        applyStimulus("ld_w");
        setPipe(1, 0, 0, 5'd9, 2'b01, 2'b11, 0, 0, 0, 32'hF000_000F);
        applyStimulus("ld_size3");
        setPipe(1, 0, 0, 5'd10, 2'b01, 2'b00, 1, 0, 0, 32'h0000_00FF);
        applyStimulus("ld_bu");
        setPipe(1, 0, 0, 5'd11, 2'b11, 2'b00, 0, 32'h0000_1004, 32'h5, 32'h6);
        applyStimulus("pc_incr");
        setPipe(1, 0, 0, 5'd12, 2'b00, 2'b00, 0, 32'h1, 32'hABCD_0123, 32'h6);
        applyStimulus("alu");
        setPipe(1, 1, 0, 5'd13, 2'b00, 2'b00, 0, 0, 32'h77, 0);
        applyStimulus("p_hold");
        checkOutput("p_hold_we",    64'(bus.rf_we_o),    64'(0));
        checkOutput("p_hold_waddr", 64'(bus.rf_waddr_o), 64'(12));
        setPipe(1, 0, 1, 5'd14, 2'b00, 2'b00, 0, 0, 32'h88, 0);
        applyStimulus("p_flush");
        setPipe(1, 0, 0, 5'd0, 2'b00, 2'b00, 0, 0, 32'h99, 0);
        applyStimulus("p_x0");

        // Channel 1 waits behind a busy pipeline until it starves
        idleAll();
        setPipe(1, 0, 0, 5'd7, 2'b00, 2'b00, 0, 0, 32'hA1A1_A1A1, 0);
        setChan(1, 1, 5'd12, 32'hCAFE_0001);
        waited    = 0;
        got_grant = 1'b0;
        for (int i = 0; i < 20 && !got_grant; i++) begin
            applyStimulus("starve");
            if (last_ready[1]) got_grant = 1'b1;
            else waited++;
        end
        checkOutput("starve_wait",  64'(waited),         64'(LIM));
        checkOutput("starve_hold",  64'(last_hold),      64'(1));
        checkOutput("starve_waddr", 64'(bus.rf_waddr_o), 64'(12));
        checkOutput("starve_wdata", 64'(bus.rf_wdata_o), 64'(32'hCAFE_0001));

        // Age channel 3 partway, then reset in a cycle that would grant it
        idleAll();
        setPipe(1, 0, 0, 5'd7, 2'b00, 2'b00, 0, 0, 32'h5, 0);
        setChan(3, 1, 5'd20, 32'h3333_0000);
        for (int i = 0; i < 5; i++) applyStimulus("age3");
        bus.p_valid_i = 1'b0;
        rst_n = 1'b0;
        applyStimulus("rst_mid");
        checkOutput("rst_mid_ready", 64'(last_ready),  64'(0));
        checkOutput("rst_mid_we",    64'(bus.rf_we_o), 64'(0));
        rst_n = 1'b1;

        // Ages restart from zero after reset
        bus.p_valid_i = 1'b1;
        waited    = 0;
        got_grant = 1'b0;
        for (int i = 0; i < 20 && !got_grant; i++) begin
            applyStimulus("post_rst");
            if (last_ready[3]) got_grant = 1'b1;
            else waited++;
        end
        checkOutput("post_rst_wait", 64'(waited), 64'(LIM));

        // Round-robin among three requesters with an idle pipeline
        rst_n = 1'b0;
        idleAll();
        applyStimulus("rst_rr");
        rst_n = 1'b1;
        for (int k = 1; k <= 3; k++) setChan(k, 1, 5'(k + 16), 32'(k * 32'h0101_0101));
        for (int i = 0; i < 4; i++) begin
            applyStimulus("rr");
            grants[i] = last_ready;
        end
        checkOutput("rr_grant0", 64'(grants[0]), 64'(3'b001));
        checkOutput("rr_grant1", 64'(grants[1]), 64'(3'b010));
        checkOutput("rr_grant2", 64'(grants[2]), 64'(3'b100));
        checkOutput("rr_grant3", 64'(grants[3]), 64'(3'b001));

        // Grant to an x0 destination during a pipeline flush
        idleAll();
        setPipe(1, 0, 1, 5'd4, 2'b00, 2'b00, 0, 0, 32'h4444, 0);
        setChan(2, 1, 5'd0, 32'hDEAD_BEEF);
        applyStimulus("flush_x0");
        checkOutput("flush_x0_ready", 64'(last_ready),  64'(3'b010));
        checkOutput("flush_x0_we",    64'(bus.rf_we_o), 64'(0));

        // Randomised traffic checked against the reference model
        for (int i = 0; i < 400; i++) begin
            rst_n = ($urandom_range(0, 63) != 0);
            setPipe($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
                    $urandom_range(0, 7) == 0, 5'($urandom_range(0, 31)),
                    2'($urandom), 2'($urandom), 1'($urandom),
                    $urandom, $urandom, $urandom);
            for (int k = 1; k <= 3; k++)
                setChan(k, $urandom_range(0, 7) != 0, 5'($urandom_range(0, 31)), $urandom);
            applyStimulus("rand");
        end

        checkOutput("sb_empty", 64'(sb_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
